// File: rtl/neuron_accumulator_pkg.sv
// neuron_accumulator_pkg: FSM states and saturating-add sizing shared by the neuron stages.
package neuron_accumulator_pkg;
    typedef enum logic [1:0] {ACCUM, BIAS, OUTPUT} state_t;
    // One guard bit above the accumulator width is enough to detect overflow of a two-operand add.
    localparam int SAT_GUARD_BITS = 1;
endpackage

// File: rtl/relu_saturate.sv
// relu_saturate: ReLU, fixed-point scale-down and unsigned saturation of the accumulator.
module relu_saturate #(
    parameter int ACC_WIDTH  = 32,
    parameter int OUT_WIDTH  = 8,
    parameter int FRAC_SHIFT = 7
) (
    input  logic signed [ACC_WIDTH-1:0] acc,
    output logic        [OUT_WIDTH-1:0] out_data
);
    logic signed [ACC_WIDTH-1:0] shifted;
    always_comb begin
        shifted  = acc >>> FRAC_SHIFT;
        out_data = acc[ACC_WIDTH-1] ? '0 :
                   |shifted[ACC_WIDTH-1:OUT_WIDTH] ? '1 : shifted[OUT_WIDTH-1:0];
    end
endmodule

// File: rtl/neuron_accumulator.sv
// neuron_accumulator: saturating multiply-accumulate tail of a neuron with bias add and ReLU output.
module neuron_accumulator
    import neuron_accumulator_pkg::*;
#(
    parameter int PROD_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int OUT_WIDTH  = 8,
    parameter int NUM_INPUTS = 784,
    parameter int FRAC_SHIFT = 7
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [ACC_WIDTH-1:0]  bias,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [PROD_WIDTH-1:0] product,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic        [OUT_WIDTH-1:0]  out_data,
    output logic                         out_ovf
);
    localparam int CW = NUM_INPUTS > 1 ? $clog2(NUM_INPUTS) : 1;
    localparam int SW = ACC_WIDTH + SAT_GUARD_BITS;

    state_t                      state, state_nx;
    logic signed [ACC_WIDTH-1:0] acc, addend, acc_sat;
    logic signed [SW-1:0]        sum;
    logic        [CW-1:0]        count;
    logic                        ovf, sat, take, last, out_fire;
    logic        [OUT_WIDTH-1:0] act;

    relu_saturate #(
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .FRAC_SHIFT(FRAC_SHIFT)
    ) u_relu (
        .acc     (acc),
        .out_data(act)
    );

    // The one adder serves both product accumulation and the bias cycle.
    always_comb begin
        in_ready  = !rst && state == ACCUM;
        out_valid = !rst && state == OUTPUT;
        take      = in_valid && in_ready;
        last      = take && count == CW'(NUM_INPUTS - 1);
        out_fire  = out_valid && out_ready;
        addend    = state == BIAS ? bias : {{(ACC_WIDTH-PROD_WIDTH){product[PROD_WIDTH-1]}}, product};
        sum       = SW'(acc) + SW'(addend);
        sat       = sum[SW-1] != sum[ACC_WIDTH-1];
        acc_sat   = sat ? {sum[SW-1], {(ACC_WIDTH-1){~sum[SW-1]}}} : sum[ACC_WIDTH-1:0];
        state_nx  = state == ACCUM ? (last ? BIAS : ACCUM) :
                    state == BIAS  ? OUTPUT : (out_fire ? ACCUM : OUTPUT);
        out_data  = out_valid ? act : '0;
        out_ovf   = out_valid && ovf;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nx;
            if (out_fire) begin
                acc <= '0;
                ovf <= 1'b0;
            end else if (take || state == BIAS) begin
                acc <= acc_sat;
                ovf <= ovf | sat;
            end
            if (take) count <= last ? '0 : count + 1'b1;
        end
    end
endmodule

// File: tb/tb_neuron_accumulator.sv
// tb_neuron_accumulator: directed vectors plus multi-cycle corner sequences for neuron_accumulator.
module tb_neuron_accumulator;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [19:0] bias = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] product = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic        [7:0]  out_data;
    logic               out_ovf;

    int errors = 0;
    int checks = 0;

    neuron_accumulator #(
        .PROD_WIDTH(16), .ACC_WIDTH(20), .OUT_WIDTH(8), .NUM_INPUTS(4), .FRAC_SHIFT(2)
    ) dut (
        .clk(clk), .rst(rst), .bias(bias), .in_valid(in_valid), .in_ready(in_ready),
        .product(product), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [15:0] p [4];
        logic signed [19:0] b;
        logic        [7:0]  data;
        logic               ovf;
    } vec_t;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic signed [15:0] p);
        int n = 0;
        in_valid = 1'b1;
        product  = p;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk("send_timeout", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
    endtask

    // Full-rate neuron with out_ready=1: checks latency, result and the freed input afterwards.
    task automatic run_neuron(input string name, input vec_t v);
        bias = v.b;
        for (int i = 0; i < 4; i++) send(v.p[i]);
        chk({name, "_bias_valid"}, int'(out_valid), 0);
        chk({name, "_bias_ready"}, int'(in_ready), 0);
        tick();
        chk({name, "_valid"}, int'(out_valid), 1);
        chk({name, "_data"}, int'(out_data), int'(v.data));
        chk({name, "_ovf"}, int'(out_ovf), int'(v.ovf));
        tick();
        chk({name, "_post_valid"}, int'(out_valid), 0);
        chk({name, "_post_ready"}, int'(in_ready), 1);
        chk({name, "_post_data"}, int'(out_data), 0);
    endtask

    vec_t vecs [7];
    vec_t v;

    initial begin
        vecs[0] = '{'{16'sd100, 16'sd200, -16'sd50, 16'sd10}, 20'sd40, 8'd75, 1'b0};
        vecs[1] = '{'{-16'sd100, -16'sd100, -16'sd100, -16'sd100}, 20'sd0, 8'd0, 1'b0};
        vecs[2] = '{'{16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767}, 20'sd524287, 8'd255, 1'b1};
        vecs[3] = '{'{16'sd0, 16'sd0, 16'sd0, 16'sd3}, 20'sd0, 8'd0, 1'b0};
        vecs[4] = '{'{16'sd1000, 16'sd0, 16'sd0, 16'sd0}, 20'sd23, 8'd255, 1'b0};
        vecs[5] = '{'{16'sd1024, 16'sd0, 16'sd0, 16'sd0}, -20'sd4, 8'd255, 1'b0};
        vecs[6] = '{'{-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768}, -20'sd524288, 8'd0, 1'b1};

        tick();
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_ovf", int'(out_ovf), 0);
        rst = 1'b0;
        #1;
        chk("rst_release_ready", int'(in_ready), 1);

        for (int i = 0; i < 7; i++) run_neuron($sformatf("vec%0d", i), vecs[i]);

        // Stalled output with input gaps; a product offered during OUTPUT must not be taken.
        out_ready = 1'b0;
        bias = '0;
        for (int i = 1; i <= 4; i++) begin
            send(16'(4 * i));
            tick();
            tick();
        end
        in_valid = 1'b1;
        product  = 16'sd999;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", int'(out_valid), 1);
            chk("stall_in_ready", int'(in_ready), 0);
            chk("stall_data", int'(out_data), 10);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("stall_release", int'(out_valid), 0);
        v = '{'{16'sd4, 16'sd4, 16'sd4, 16'sd4}, 20'sd0, 8'd4, 1'b0};
        run_neuron("after_stall", v);

        // Reset mid-neuron discards the partial sum and restarts the count.
        bias = 20'sd5000;
        send(16'sd1000);
        send(16'sd1000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("abort_no_valid", int'(out_valid), 0);
            tick();
        end
        v = '{'{16'sd10, 16'sd10, 16'sd10, 16'sd10}, 20'sd0, 8'd10, 1'b0};
        run_neuron("after_rst", v);

        // Reset while a result is pending in OUTPUT drops it.
        out_ready = 1'b0;
        bias = '0;
        for (int i = 0; i < 4; i++) send(16'sd100);
        tick();
        chk("pend_valid", int'(out_valid), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("pend_dropped", int'(out_valid), 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
